// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-bit shift sequencer iterating an external 1-bit shift unit
// Latches one request, feeds the shift unit result back once per clock, then pulses done.
module shift_sequencer #(
    parameter int         DATA_WIDTH = 16,
    parameter int         CNT_WIDTH  = 4,
    parameter logic [3:0] FUNC_LLS   = 4'h8,
    parameter logic [3:0] FUNC_LRS   = 4'h9,
    parameter logic [3:0] FUNC_ALS   = 4'hA,
    parameter logic [3:0] FUNC_ARS   = 4'hB
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            FuncCode,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] C,
    output logic                  OverflowFlag,
    output logic [DATA_WIDTH-1:0] sh_A,
    output logic [DATA_WIDTH-1:0] sh_B,
    output logic [3:0]            sh_FuncCode,
    input  logic [DATA_WIDTH-1:0] sh_C,
    input  logic                  sh_OverflowFlag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [3:0]            func_q, func_d;
    logic                  ovf_q, ovf_d;
    logic                  ovf_out_q, ovf_out_d;
    logic                  is_shift;
    logic [CNT_WIDTH-1:0]  amount;

    assign is_shift = (FuncCode == FUNC_LLS) || (FuncCode == FUNC_LRS) ||
                      (FuncCode == FUNC_ALS) || (FuncCode == FUNC_ARS);
    assign amount   = B[CNT_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            b_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            func_q    <= '0;
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            func_q    <= func_d;
            ovf_q     <= ovf_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        func_d    = func_q;
        ovf_d     = ovf_q;
        ovf_out_d = ovf_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d  = A;
                    func_d = FuncCode;
                    b_d    = B;
                    cnt_d  = amount;
                    ovf_d  = 1'b0;
                    if (!is_shift) begin
                        // Unsupported function codes complete immediately with a zero result.
                        acc_d     = '0;
                        c_d       = '0;
                        ovf_out_d = 1'b0;
                        state_d   = DONE;
                    end else if (amount == '0) begin
                        c_d       = A;
                        ovf_out_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = sh_C;
                ovf_d = ovf_q | sh_OverflowFlag;
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    c_d       = sh_C;
                    ovf_out_d = ovf_q | sh_OverflowFlag;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q == RUN) || (state_q == DONE);
    assign done         = (state_q == DONE);
    assign C            = c_q;
    assign OverflowFlag = ovf_out_q;
    assign sh_A         = acc_q;
    assign sh_B         = b_q;
    assign sh_FuncCode  = func_q;

endmodule
